// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared UART constants, receiver state encoding and vote helper
package uart_rx_pkg;

    localparam int UART_OVERSAMPLE = 8;
    localparam int UART_DATA_BITS  = 8;

    localparam logic [2:0] PH_LAST   = 3'(UART_OVERSAMPLE - 1);
    localparam logic [2:0] IDX_LAST  = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0] VOTE_PH_A = 3'd3;
    localparam logic [2:0] VOTE_PH_B = 3'd4;
    localparam logic [2:0] VOTE_PH_C = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - one-cycle pulse on each rising edge of the baud*8 enable source
module uart_baud_tick (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_baud8_clk,
    output logic o_tick
);

    logic [1:0] hist;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hist <= 2'b00;
        end else begin
            hist <= {hist[0], i_baud8_clk};
        end
    end

    assign o_tick = hist[0] & ~hist[1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 3-sample majority vote and one-byte buffer
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_baud8_clk,
    input  logic       i_rx,
    input  logic       i_rd,
    output logic [7:0] o_data,
    output logic       o_rxne,
    output logic       o_ore,
    output logic       o_fe,
    output logic       o_bsy
);

    logic                      tick;
    logic [SYNC_STAGES-1:0]    sync_q;
    logic                      rxs;
    logic                      rxs_prev;
    rx_state_e                 state;
    logic [2:0]                ph;
    logic [2:0]                bit_idx;
    logic [1:0]                samp;
    logic                      bitval_q;
    logic                      vote_now;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      accept_q;

    uart_baud_tick u_tick (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_baud8_clk (i_baud8_clk),
        .o_tick      (tick)
    );

    // Reset to idle-high so a reset never fabricates a falling edge on an idle line
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q   <= '1;
            rxs_prev <= 1'b1;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], i_rx};
            rxs_prev <= rxs;
        end
    end

    assign rxs      = sync_q[SYNC_STAGES-1];
    assign vote_now = majority3(samp[0], samp[1], rxs);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= S_IDLE;
            ph       <= '0;
            bit_idx  <= '0;
            samp     <= '0;
            bitval_q <= 1'b1;
            shreg    <= '0;
            accept_q <= 1'b0;
            o_fe     <= 1'b0;
            o_bsy    <= 1'b0;
        end else begin
            accept_q <= 1'b0;
            o_fe     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rxs_prev && !rxs) begin
                        state <= S_START;
                        ph    <= '0;
                        o_bsy <= 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rxs) begin
                        state <= S_IDLE;
                        o_bsy <= 1'b0;
                    end
                end
                default: begin
                    if (tick) begin
                        ph <= ph + 3'd1;
                        if (ph == VOTE_PH_A) samp[0] <= rxs;
                        if (ph == VOTE_PH_B) samp[1] <= rxs;
                        if (ph == VOTE_PH_C) bitval_q <= vote_now;
                        // Stop bit is judged on its last vote sample to leave slack for the next start
                        if (state == S_STOP && ph == VOTE_PH_C) begin
                            if (vote_now) begin
                                accept_q <= 1'b1;
                                state    <= S_IDLE;
                                o_bsy    <= 1'b0;
                            end else begin
                                o_fe  <= 1'b1;
                                state <= S_BREAK;
                            end
                        end else if (ph == PH_LAST) begin
                            if (state == S_START) begin
                                if (bitval_q) begin
                                    state <= S_IDLE;
                                    o_bsy <= 1'b0;
                                end else begin
                                    state   <= S_DATA;
                                    bit_idx <= '0;
                                end
                            end else if (state == S_DATA) begin
                                shreg   <= {bitval_q, shreg[UART_DATA_BITS-1:1]};
                                bit_idx <= bit_idx + 3'd1;
                                if (bit_idx == IDX_LAST) state <= S_STOP;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data <= 8'h00;
            o_rxne <= 1'b0;
            o_ore  <= 1'b0;
        end else begin
            if (accept_q && (!o_rxne || i_rd)) begin
                o_data <= shreg;
                o_rxne <= 1'b1;
            end else if (i_rd) begin
                o_rxne <= 1'b0;
            end
            if (i_rd) begin
                o_ore <= 1'b0;
            end else if (accept_q && o_rxne) begin
                o_ore <= 1'b1;
            end
        end
    end

endmodule
